seg_scan_display: RTL and testbench
===================================

SEG_SCAN_DISPLAY -- requirements
Module: seg_scan_display

Interface
REQ-001 Parameter: SCAN_DIV, default 16, prescaler width; one digit-advance tick every 2^SCAN_DIV clocks.
REQ-002 disp_clk  input  1  sole clock; all state on rising edge.
REQ-003 rst_in  input  1  asynchronous, active-low reset.
REQ-004 data  input  32  word to display (CPU buffer / PC / IR as muxed upstream).
REQ-005 data_vld  input  1  data valid; transfer when data_vld && data_rdy.
REQ-006 data_rdy  output  1  pending slot empty, new word accepted.
REQ-007 half_sel  input  1  0 = show data[15:0], 1 = show data[31:16].
REQ-008 an  output  4  digit anodes, active-low, one-hot-low when lit.
REQ-009 seg  output  8  {dp, g,f,e,d,c,b,a}, active-low.

Function
REQ-010 Prescaler: SCAN_DIV-bit up-counter, wraps; tick = counter all-ones.
REQ-011 Digit index: 2-bit, increments on tick, wraps 3->0; frame_end = tick && index==3.
REQ-012 Two-stage buffer: pend (32b) + pend_full, and disp (32b) + disp_half (1b).
REQ-013 data_rdy SHALL equal !pend_full (combinational from register).
REQ-014 On data_vld && data_rdy: pend <= data, pend_full <= 1.
REQ-015 On frame_end: disp_half <= half_sel; if pend_full, disp <= pend and pend_full <= 0.
REQ-016 Simultaneous frame_end and data_vld with pend_full=1: transfer pend->disp, data not accepted that cycle, data_rdy=1 next cycle.
REQ-017 Simultaneous frame_end and accepted data_vld (pend_full=0): new word goes to pend, disp unchanged.
REQ-018 Displayed nibble for index i = disp[16*disp_half + 4*i +: 4]; digit 0 = rightmost (an[0]).
REQ-019 Hex decode (seg[6:0], active-low): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
REQ-020 dp (seg[7]) = 0 only on digit 3 when disp_half=1; else 1.
REQ-021 an and seg registered: output reflects index one clock after index update.
REQ-022 Anti-ghost: in the clock following each tick, an SHALL be 4'hF; normal drive resumes next clock.
REQ-023 No tearing: disp and disp_half change only on frame_end.

Reset
REQ-024 While rst_in=0: prescaler=0, index=0, pend=0, pend_full=0, disp=0, disp_half=0, an=4'hF, seg=8'hFF, data_rdy=1.
REQ-025 Reset mid-frame or with pend_full=1 discards pending word; first lit digit after release is digit 0 showing "0".

Structure
REQ-026 Shared package: SCAN_DIV default, 16-entry hex segment table, AN_OFF=4'hF, SEG_OFF=8'hFF.
REQ-027 One sub-module: hex7seg (4-bit nibble in, 7-bit active-low segments out, combinational).
REQ-028 Top module holds prescaler, index, buffers, output registers; target 120-250 lines RTL.

Verification (SCAN_DIV=4, tick every 16 clocks)
REQ-029 Hold rst_in=0 5 clocks -> an=F, seg=FF, data_rdy=1; release -> first an=E with seg=C0.
REQ-030 Load 32'h1234_ABCD, half_sel=0 -> after next frame_end digits 0..3 show D,C,B,A: seg=A1,C6,83,88 with an=E,D,B,7; dp=1.
REQ-031 half_sel=1 -> after next frame_end digit 3 shows 1 with seg=79 (dp=0), digit 0 shows 4 (seg=99).
REQ-032 Two back-to-back vld words before frame_end -> second cycle data_rdy=0, first word kept; after frame_end data_rdy=1 and second word accepted.
REQ-033 Check each tick: next clock an=F exactly one cycle; vld coincident with frame_end and pend_full=1 -> not accepted, accepted one cycle later.
REQ-034 Assert rst_in low mid-frame with pend_full=1 -> immediate an=F, seg=FF, data_rdy=1; display after release shows 0000.

Source files
------------

// File: rtl/seg_scan_display_pkg.sv
// seg_scan_display_pkg: shared constants and hex segment table for the scanned 4-digit display.
//   SCAN_DIV_DEF : default prescaler width (one digit advance every 2^SCAN_DIV clocks)
//   AN_OFF       : anode pattern with every digit dark (active-low)
//   SEG_OFF      : segment pattern with every segment dark (active-low)
//   HEX_SEG      : active-low {g,f,e,d,c,b,a} pattern for each hex nibble, entry n = nibble n
package seg_scan_display_pkg;
    localparam int SCAN_DIV_DEF = 16;
    localparam logic [3:0] AN_OFF = 4'hF;
    localparam logic [7:0] SEG_OFF = 8'hFF;
    // Listed F down to 0 so that HEX_SEG[n] selects nibble n.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };
endpackage

// File: rtl/seg_scan_display_hex7seg.sv
// hex7seg: combinational hex nibble to active-low seven-segment decoder.
//   nib   : input  4  nibble to show
//   seg_n : output 7  {g,f,e,d,c,b,a}, active-low
module hex7seg
    import seg_scan_display_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg_n
);
    assign seg_n = HEX_SEG[nib];
endmodule

// File: rtl/seg_scan_display.sv
// seg_scan_display: time-multiplexed 4-digit hex display driver with tear-free double buffering.
//   disp_clk : input  1   sole clock, rising edge
//   rst_in   : input  1   asynchronous active-low reset
//   data     : input  32  word to display
//   data_vld : input  1   word valid; taken when data_vld && data_rdy
//   data_rdy : output 1   pending slot empty
//   half_sel : input  1   0 shows data[15:0], 1 shows data[31:16]
//   an       : output 4   digit anodes, active-low, digit 0 rightmost
//   seg      : output 8   {dp,g,f,e,d,c,b,a}, active-low
module seg_scan_display
    import seg_scan_display_pkg::*;
#(
    parameter int SCAN_DIV = SCAN_DIV_DEF
) (
    input  logic        disp_clk,
    input  logic        rst_in,
    input  logic [31:0] data,
    input  logic        data_vld,
    output logic        data_rdy,
    input  logic        half_sel,
    output logic [3:0]  an,
    output logic [7:0]  seg
);
    logic [SCAN_DIV-1:0] presc_q, presc_d;
    logic [1:0]          idx_q, idx_d;
    logic [31:0]         pend_q, pend_d, disp_q, disp_d;
    logic                pend_full_q, pend_full_d, disp_half_q, disp_half_d;
    logic [3:0]          an_q, an_d;
    logic [7:0]          seg_q, seg_d;
    logic                tick, frame_end, accept;
    logic [3:0]          nib;
    logic [6:0]          hex_seg;

    assign tick      = &presc_q;
    assign frame_end = tick && idx_q == 2'd3;
    assign accept    = data_vld && !pend_full_q;
    assign data_rdy  = !pend_full_q;
    // Bit offset 16*half + 4*index packed as {half, index, 2'b00}.
    assign nib       = disp_q[{disp_half_q, idx_q, 2'b00} +: 4];
    assign an        = an_q;
    assign seg       = seg_q;

    hex7seg u_hex7seg (
        .nib   (nib),
        .seg_n (hex_seg)
    );

    always_comb begin
        presc_d     = presc_q + 1'b1;
        idx_d       = tick ? idx_q + 2'd1 : idx_q;
        pend_d      = accept ? data : pend_q;
        // A full slot is never accepted into, so accept and the frame_end drain never collide.
        pend_full_d = accept || (pend_full_q && !frame_end);
        disp_d      = (frame_end && pend_full_q) ? pend_q : disp_q;
        disp_half_d = frame_end ? half_sel : disp_half_q;
        // Blank for one clock after every digit change so the old pattern never shows on the new anode.
        an_d        = tick ? AN_OFF : ~(4'b0001 << idx_q);
        seg_d       = tick ? SEG_OFF : {~(disp_half_q && idx_q == 2'd3), hex_seg};
    end

    always_ff @(posedge disp_clk or negedge rst_in) begin
        if (!rst_in) begin
            presc_q     <= '0;
            idx_q       <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            disp_q      <= '0;
            disp_half_q <= 1'b0;
            an_q        <= AN_OFF;
            seg_q       <= SEG_OFF;
        end else begin
            presc_q     <= presc_d;
            idx_q       <= idx_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            disp_q      <= disp_d;
            disp_half_q <= disp_half_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
        end
    end
endmodule

// File: tb/tb_seg_scan_display.sv
// tb_seg_scan_display: directed scoreboard bench for seg_scan_display with SCAN_DIV=4.
module tb_seg_scan_display;
    typedef struct {
        logic [3:0] an;
        logic [7:0] seg;
    } exp_t;

    logic        disp_clk = 1'b0;
    logic        rst_in   = 1'b0;
    logic [31:0] data     = '0;
    logic        data_vld = 1'b0;
    logic        half_sel = 1'b0;
    logic        data_rdy;
    logic [3:0]  an;
    logic [7:0]  seg;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    logic [6:0] hex_tb [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seg_scan_display #(.SCAN_DIV(4)) dut (
        .disp_clk (disp_clk),
        .rst_in   (rst_in),
        .data     (data),
        .data_vld (data_vld),
        .data_rdy (data_rdy),
        .half_sel (half_sel),
        .an       (an),
        .seg      (seg)
    );

    always #5 disp_clk = ~disp_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [31:0] w, input logic half);
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            int   off;
            off   = (half ? 16 : 0) + 4 * i;
            e.an  = ~(4'b0001 << i);
            e.seg = {~(half && i == 3), hex_tb[w[off +: 4]]};
            sb.push_back(e);
        end
    endtask

    task automatic check_digit(input string tag);
        exp_t e;
        int   n = 0;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 0, 1);
            return;
        end
        e = sb.pop_front();
        while (an !== e.an && n < 40) begin
            @(negedge disp_clk);
            n++;
        end
        chk({tag, "_an"}, an, e.an);
        chk({tag, "_seg"}, seg, e.seg);
    endtask

    task automatic check_frame(input string tag);
        for (int i = 0; i < 4; i++) check_digit($sformatf("%s_d%0d", tag, i));
    endtask

    task automatic wait_frame(input string tag);
        int   n = 0;
        logic prev_blank = 1'b0;
        logic found = 1'b0;
        while (!found && n < 200) begin
            @(negedge disp_clk);
            n++;
            if (prev_blank && an === 4'hE) found = 1'b1;
            prev_blank = (an === 4'hF);
        end
        chk({tag, "_frame_seen"}, found, 1);
    endtask

    task automatic check_blank(input string tag);
        int n = 0;
        while (an !== 4'hF && n < 40) begin
            @(negedge disp_clk);
            n++;
        end
        chk({tag, "_blank"}, an, 4'hF);
        @(negedge disp_clk);
        chk({tag, "_lit_after_one"}, $countones(~an), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held for 5 clocks.
        repeat (5) @(negedge disp_clk);
        chk("rst_an", an, 4'hF);
        chk("rst_seg", seg, 8'hFF);
        chk("rst_rdy", data_rdy, 1);
        rst_in = 1'b1;
        @(negedge disp_clk);
        chk("first_an", an, 4'hE);
        chk("first_seg", seg, 8'hC0);
        push_frame(32'h0, 1'b0);
        check_frame("zero");
        // Anti-ghost: every tick is followed by exactly one dark clock.
        check_blank("tick_a");
        chk("tick_a_digit0", an, 4'hE);
        check_blank("tick_b");
        chk("tick_b_digit1", an, 4'hD);

        // Low half of 1234_ABCD.
        chk("load1_rdy", data_rdy, 1);
        data = 32'h1234_ABCD;
        data_vld = 1'b1;
        @(negedge disp_clk);
        data_vld = 1'b0;
        chk("load1_full", data_rdy, 0);
        wait_frame("low");
        chk("low_rdy", data_rdy, 1);
        push_frame(32'h1234_ABCD, 1'b0);
        check_frame("low");

        // High half, same displayed word.
        half_sel = 1'b1;
        wait_frame("high");
        push_frame(32'h1234_ABCD, 1'b1);
        check_frame("high");

        // Back-to-back words; the second is held against frame_end while the slot is full.
        half_sel = 1'b0;
        data = 32'h1111_1111;
        data_vld = 1'b1;
        chk("b2b_rdy0", data_rdy, 1);
        @(negedge disp_clk);
        chk("b2b_rdy1", data_rdy, 0);
        data = 32'h2222_2222;
        begin
            int n = 0;
            while (data_rdy !== 1'b1 && n < 60) begin
                @(negedge disp_clk);
                n++;
            end
        end
        chk("b2b_rdy_after_frame", data_rdy, 1);
        chk("b2b_frame_blank", an, 4'hF);
        @(negedge disp_clk);
        data_vld = 1'b0;
        chk("b2b_second_taken", data_rdy, 0);
        push_frame(32'h1111_1111, 1'b0);
        check_frame("first_word");
        wait_frame("second");
        push_frame(32'h2222_2222, 1'b0);
        check_frame("second_word");

        // Reset mid-frame with a word pending.
        data = 32'h9999_9999;
        data_vld = 1'b1;
        @(negedge disp_clk);
        data_vld = 1'b0;
        chk("pre_rst_full", data_rdy, 0);
        repeat (3) @(negedge disp_clk);
        rst_in = 1'b0;
        #1;
        chk("mid_rst_an", an, 4'hF);
        chk("mid_rst_seg", seg, 8'hFF);
        chk("mid_rst_rdy", data_rdy, 1);
        repeat (3) @(negedge disp_clk);
        rst_in = 1'b1;
        @(negedge disp_clk);
        chk("post_rst_an", an, 4'hE);
        chk("post_rst_seg", seg, 8'hC0);
        push_frame(32'h0, 1'b0);
        check_frame("post_rst");
        wait_frame("post_rst2");
        push_frame(32'h0, 1'b0);
        check_frame("post_rst2");

        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
